// File: rtl/dds_pattern_sequencer_if.sv
// Control-side bundle of the DDS segment sequencer: table programming, playback control, DDS drive.
// DDS_SEQ_CHIRP_EN adds the per-segment frequency step word cfg_fstep.
interface dds_pattern_sequencer_if #(
  parameter int WIDTH_PHASE    = 32,
  parameter int WIDTH_NCO      = 16,
  parameter int WIDTH_SEG_ADDR = 4,
  parameter int WIDTH_DUR      = 16
);
  logic                      cfg_we;
  logic [WIDTH_SEG_ADDR-1:0] cfg_addr;
  logic [WIDTH_PHASE-1:0]    cfg_freq;
  logic [WIDTH_PHASE-1:0]    cfg_phase;
  logic [WIDTH_NCO-1:0]      cfg_ampl;
  logic [WIDTH_DUR-1:0]      cfg_dur;
`ifdef DDS_SEQ_CHIRP_EN
  logic [WIDTH_PHASE-1:0]    cfg_fstep;
`endif
  logic [WIDTH_SEG_ADDR-1:0] last_seg;
  logic                      loop_en;
  logic                      start;
  logic                      stop;

  logic [WIDTH_PHASE-1:0]    frequency;
  logic [WIDTH_PHASE-1:0]    phase;
  logic [WIDTH_NCO-1:0]      amplitude;
  logic                      dds_start;
  logic [WIDTH_SEG_ADDR-1:0] seg_idx;
  logic                      busy;
  logic                      done;

  modport master (
`ifdef DDS_SEQ_CHIRP_EN
    output cfg_fstep,
`endif
    output cfg_we, cfg_addr, cfg_freq, cfg_phase, cfg_ampl, cfg_dur,
    output last_seg, loop_en, start, stop,
    input  frequency, phase, amplitude, dds_start, seg_idx, busy, done
  );

  modport slave (
`ifdef DDS_SEQ_CHIRP_EN
    input  cfg_fstep,
`endif
    input  cfg_we, cfg_addr, cfg_freq, cfg_phase, cfg_ampl, cfg_dur,
    input  last_seg, loop_en, start, stop,
    output frequency, phase, amplitude, dds_start, seg_idx, busy, done
  );
endinterface

// File: rtl/dds_pattern_sequencer.sv
// Segment table sequencer feeding the DDS frequency/phase/amplitude/start inputs (burst or loop).
// Optional feature DDS_SEQ_CHIRP_EN: per-segment linear frequency step applied every clock.
module dds_pattern_sequencer #(
  parameter int WIDTH_PHASE    = 32,
  parameter int WIDTH_NCO      = 16,
  parameter int WIDTH_SEG_ADDR = 4,
  parameter int WIDTH_DUR      = 16
) (
  input  logic                   clk,
  input  logic                   reset_b,
  dds_pattern_sequencer_if.slave bus
);

  localparam int N_SEG = 2 ** WIDTH_SEG_ADDR;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Segment table
  logic [WIDTH_PHASE-1:0] freq_mem  [N_SEG];
  logic [WIDTH_PHASE-1:0] phase_mem [N_SEG];
  logic [WIDTH_NCO-1:0]   ampl_mem  [N_SEG];
  logic [WIDTH_DUR-1:0]   dur_mem   [N_SEG];
`ifdef DDS_SEQ_CHIRP_EN
  logic [WIDTH_PHASE-1:0] fstep_mem [N_SEG];
`endif

  state_t                    state_q;
  logic                      start_q;
  logic [WIDTH_SEG_ADDR-1:0] last_seg_q;
  logic                      loop_en_q;
  logic [WIDTH_DUR-1:0]      dur_q;
  logic [WIDTH_PHASE-1:0]    frequency_q;
  logic [WIDTH_PHASE-1:0]    phase_q;
  logic [WIDTH_NCO-1:0]      amplitude_q;
  logic                      dds_start_q;
  logic [WIDTH_SEG_ADDR-1:0] seg_idx_q;
  logic                      busy_q;
  logic                      done_q;
`ifdef DDS_SEQ_CHIRP_EN
  logic [WIDTH_PHASE-1:0]    fstep_q;
`endif

  logic                      start_strobe;
  logic                      table_we;
  logic                      seg_last;
  logic [WIDTH_SEG_ADDR-1:0] seg_idx_d;
  logic [WIDTH_SEG_ADDR-1:0] rd_idx;
  logic [WIDTH_DUR-1:0]      rd_dur;

  assign start_strobe = bus.start & ~start_q;
  assign table_we     = bus.cfg_we && (state_q != S_RUN);

  // NOTE: the table has no reset branch, so it maps to plain RAM and survives reset_b.
  always_ff @(posedge clk) begin
    if (table_we) begin
      freq_mem[bus.cfg_addr]  <= bus.cfg_freq;
      phase_mem[bus.cfg_addr] <= bus.cfg_phase;
      ampl_mem[bus.cfg_addr]  <= bus.cfg_ampl;
      dur_mem[bus.cfg_addr]   <= bus.cfg_dur;
`ifdef DDS_SEQ_CHIRP_EN
      fstep_mem[bus.cfg_addr] <= bus.cfg_fstep;
`endif
    end
  end

  // Segment to enter next: wrap to 0 only through the last_seg compare.
  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    seg_last  = (seg_idx_q == last_seg_q);
    seg_idx_d = seg_last ? '0 : seg_idx_q + 1'b1;
    rd_idx    = (state_q == S_RUN) ? seg_idx_d : '0;
    rd_dur    = (dur_mem[rd_idx] == '0) ? WIDTH_DUR'(1) : dur_mem[rd_idx];
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      last_seg_q  <= '0;
      loop_en_q   <= 1'b0;
      dur_q       <= '0;
      frequency_q <= '0;
      phase_q     <= '0;
      amplitude_q <= '0;
      dds_start_q <= 1'b0;
      seg_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DDS_SEQ_CHIRP_EN
      fstep_q     <= '0;
`endif
    end else begin
      start_q     <= bus.start;
      dds_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (bus.stop) begin
        state_q     <= S_IDLE;
        dur_q       <= '0;
        frequency_q <= '0;
        phase_q     <= '0;
        amplitude_q <= '0;
        seg_idx_q   <= '0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_strobe) begin
              state_q     <= S_RUN;
              last_seg_q  <= bus.last_seg;
              loop_en_q   <= bus.loop_en;
              dur_q       <= rd_dur;
              frequency_q <= freq_mem[rd_idx];
              phase_q     <= phase_mem[rd_idx];
              amplitude_q <= ampl_mem[rd_idx];
`ifdef DDS_SEQ_CHIRP_EN
              fstep_q     <= fstep_mem[rd_idx];
`endif
              seg_idx_q   <= '0;
              busy_q      <= 1'b1;
              dds_start_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (dur_q == WIDTH_DUR'(1)) begin
              if (seg_last && !loop_en_q) begin
                state_q     <= S_DONE;
                dur_q       <= '0;
                frequency_q <= '0;
                phase_q     <= '0;
                amplitude_q <= '0;
                seg_idx_q   <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                // Segment change (including loop wrap) keeps the DDS phase running.
                dur_q       <= rd_dur;
                frequency_q <= freq_mem[rd_idx];
                phase_q     <= phase_mem[rd_idx];
                amplitude_q <= ampl_mem[rd_idx];
`ifdef DDS_SEQ_CHIRP_EN
                fstep_q     <= fstep_mem[rd_idx];
`endif
                seg_idx_q   <= seg_idx_d;
              end
            end else begin
              dur_q <= dur_q - 1'b1;
`ifdef DDS_SEQ_CHIRP_EN
              frequency_q <= frequency_q + fstep_q;
`endif
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.frequency = frequency_q;
  assign bus.phase     = phase_q;
  assign bus.amplitude = amplitude_q;
  assign bus.dds_start = dds_start_q;
  assign bus.seg_idx   = seg_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_dds_pattern_sequencer.sv
// Self-checking bench for dds_pattern_sequencer: cycle vector table, directed corners, random runs
// against a segment-expansion reference model.
module tb_dds_pattern_sequencer;

  localparam int WP = 32;
  localparam int WN = 16;
  localparam int WA = 4;
  localparam int WD = 16;
  localparam int NS = 16;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  dds_pattern_sequencer_if #(.WIDTH_PHASE(WP), .WIDTH_NCO(WN), .WIDTH_SEG_ADDR(WA),
                             .WIDTH_DUR(WD)) bus ();

  dds_pattern_sequencer #(.WIDTH_PHASE(WP), .WIDTH_NCO(WN), .WIDTH_SEG_ADDR(WA),
                          .WIDTH_DUR(WD)) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [WP-1:0] f;
    logic [WP-1:0] p;
    logic [WN-1:0] a;
    logic [WA-1:0] seg;
    logic          busy;
    logic          dds;
    logic          done;
  } frame_t;

  task automatic check_frame(input string tag, input frame_t e);
    check({tag, ".freq"},  64'(bus.frequency), 64'(e.f));
    check({tag, ".phase"}, 64'(bus.phase),     64'(e.p));
    check({tag, ".ampl"},  64'(bus.amplitude), 64'(e.a));
    check({tag, ".seg"},   64'(bus.seg_idx),   64'(e.seg));
    check({tag, ".busy"},  64'(bus.busy),      64'(e.busy));
    check({tag, ".dds"},   64'(bus.dds_start), 64'(e.dds));
    check({tag, ".done"},  64'(bus.done),      64'(e.done));
  endtask

  // Shadow of what the table should hold
  logic [WP-1:0] m_f [NS];
  logic [WP-1:0] m_p [NS];
  logic [WP-1:0] m_s [NS];
  logic [WN-1:0] m_a [NS];
  logic [WD-1:0] m_d [NS];

  frame_t trace [$];
  frame_t idle_fr;
  frame_t done_fr;

  task automatic write_seg(input int addr, input logic [WP-1:0] f, input logic [WP-1:0] p,
                           input logic [WN-1:0] a, input logic [WD-1:0] d,
                           input logic [WP-1:0] s);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = WA'(addr);
    bus.cfg_freq  = f;
    bus.cfg_phase = p;
    bus.cfg_ampl  = a;
    bus.cfg_dur   = d;
`ifdef DDS_SEQ_CHIRP_EN
    bus.cfg_fstep = s;
`endif
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_f[addr] = f; m_p[addr] = p; m_a[addr] = a; m_d[addr] = d; m_s[addr] = s;
  endtask

  // Expected playback: each segment repeated max(dur,1) times, in order 0..last.
  task automatic build_trace(input int last);
    frame_t fr;
    int     d;
    trace.delete();
    for (int i = 0; i <= last; i++) begin
      d = (m_d[i] == 0) ? 1 : int'(m_d[i]);
      for (int j = 0; j < d; j++) begin
        fr.f = m_f[i];
`ifdef DDS_SEQ_CHIRP_EN
        fr.f = m_f[i] + m_s[i] * WP'(j);
`endif
        fr.p = m_p[i]; fr.a = m_a[i]; fr.seg = WA'(i);
        fr.busy = 1'b1; fr.dds = 1'b0; fr.done = 1'b0;
        trace.push_back(fr);
      end
    end
  endtask

  // Frame k is what the outputs show k cycles after the edge that samples the start edge.
  task automatic run_scenario(input string tag, input int last, input bit loop, input int ncyc,
                              input int stop_k, input int we_k);
    frame_t e;
    int     len;
    build_trace(last);
    len = trace.size();
    bus.last_seg = WA'(last);
    bus.loop_en  = loop;
    bus.start    = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (stop_k >= 0 && k > stop_k) e = idle_fr;
      else if (loop)                 e = trace[k % len];
      else if (k < len)              e = trace[k];
      else if (k == len)             e = done_fr;
      else                           e = idle_fr;
      if (e.busy) e.dds = (k == 0);
      check_frame($sformatf("%s[%0d]", tag, k), e);
      bus.start = 1'b0;
      if (k == 0) begin
        bus.last_seg = WA'($urandom);
        bus.loop_en  = $urandom_range(0, 1) != 0;
      end
      bus.stop = (k == stop_k);
      if (k == we_k) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = WA'(1);
        bus.cfg_freq  = ~m_f[1];
        bus.cfg_phase = ~m_p[1];
        bus.cfg_ampl  = ~m_a[1];
        bus.cfg_dur   = m_d[1] + 1'b1;
      end else begin
        bus.cfg_we = 1'b0;
      end
    end
    bus.cfg_we = 1'b0;
    bus.stop   = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
    check_frame({tag, ".end"}, idle_fr);
  endtask

  typedef struct {
    logic          start;
    logic          stop;
    logic [WP-1:0] f;
    logic [WA-1:0] seg;
    logic          busy;
    logic          dds;
    logic          done;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int last, len, ncyc, stop_k;
    bit loop;

    idle_fr = '{f: '0, p: '0, a: '0, seg: '0, busy: 1'b0, dds: 1'b0, done: 1'b0};
    done_fr = idle_fr;
    done_fr.done = 1'b1;

    //               start stop  freq      seg busy dds done
    vecs[0]  = '{1'b1, 1'b0, 32'h1000, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1000, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h1000, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1000, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h2000, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h2000, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h3000, 4'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h1000, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    reset_b       = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_freq  = '0;
    bus.cfg_phase = '0;
    bus.cfg_ampl  = '0;
    bus.cfg_dur   = '0;
`ifdef DDS_SEQ_CHIRP_EN
    bus.cfg_fstep = '0;
`endif
    bus.last_seg  = '0;
    bus.loop_en   = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    repeat (2) @(negedge clk);
    check_frame("reset", idle_fr);
    reset_b = 1'b1;
    @(negedge clk);
    check_frame("post_reset", idle_fr);

    write_seg(0, 32'h1000, 32'h11, 16'h000A, 16'd4, '0);
    write_seg(1, 32'h2000, 32'h22, 16'h000B, 16'd2, '0);
    write_seg(2, 32'h3000, 32'h33, 16'h000C, 16'd0, '0);

    // Burst, restart-ignore, done pulse, re-arm and stop via the vector table
    bus.last_seg = 4'd2;
    bus.loop_en  = 1'b0;
    for (int r = 0; r < 12; r++) begin
      bus.start = vecs[r].start;
      bus.stop  = vecs[r].stop;
      @(negedge clk);
      check($sformatf("vec%0d.freq", r), 64'(bus.frequency), 64'(vecs[r].f));
      check($sformatf("vec%0d.seg", r),  64'(bus.seg_idx),   64'(vecs[r].seg));
      check($sformatf("vec%0d.busy", r), 64'(bus.busy),      64'(vecs[r].busy));
      check($sformatf("vec%0d.dds", r),  64'(bus.dds_start), 64'(vecs[r].dds));
      check($sformatf("vec%0d.done", r), 64'(bus.done),      64'(vecs[r].done));
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clk);

    run_scenario("burst", 2, 1'b0, 10, -1, -1);
    run_scenario("loop", 2, 1'b1, 20, -1, -1);
    run_scenario("stop_seg1", 2, 1'b0, 10, 4, -1);
    run_scenario("cfg_lock", 2, 1'b0, 10, -1, 4);
    run_scenario("readback", 2, 1'b0, 10, -1, -1);

    // Reset in the middle of segment 0, then table must still play
    bus.last_seg = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    check("midrst.busy", 64'(bus.busy), 64'(0));
    check("midrst.freq", 64'(bus.frequency), 64'(0));
    check("midrst.ampl", 64'(bus.amplitude), 64'(0));
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    check_frame("midrst.idle", idle_fr);
    run_scenario("after_reset", 2, 1'b0, 10, -1, -1);

`ifdef DDS_SEQ_CHIRP_EN
    write_seg(0, 32'h100, 32'h0, 16'h1, 16'd4, 32'h10);
    run_scenario("chirp", 0, 1'b0, 7, -1, -1);
`endif

    // Full table, all 16 segments, dur 0 clamps to 1
    for (int i = 0; i < NS; i++)
      write_seg(i, WP'(32'h100 * (i + 1)), WP'(i), WN'(i + 1), WD'(i % 2), WP'(i));
    run_scenario("full16", 15, 1'b0, 28, -1, -1);
    run_scenario("full16_loop", 15, 1'b1, 40, -1, -1);

    repeat (25) begin
      for (int i = 0; i < NS; i++)
        write_seg(i, WP'($urandom), WP'($urandom), WN'($urandom), WD'($urandom_range(0, 4)),
                  WP'($urandom));
      last = $urandom_range(0, NS - 1);
      loop = $urandom_range(0, 1) != 0;
      build_trace(last);
      len  = trace.size();
      ncyc = loop ? $urandom_range(5, 60) : len + 3;
      stop_k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ncyc - 1) : -1;
      run_scenario("rand", last, loop, ncyc, stop_k, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
